// File: rtl/muldiv_hilo_pkg.sv
// Shared definitions for the multiply/divide unit and the control decoder:
// op encodings, FSM state encoding and the default operand width.
package muldiv_hilo_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned shift-add multiplier or restoring divider.
// The divide path exists only when MULDIV_HILO_DIV_EN is defined.
module muldiv_step
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] mul_sum;

`ifdef MULDIV_HILO_DIV_EN
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
`else
  logic unused_is_div;
  assign unused_is_div = is_div;
`endif

  // NOTE: every signal written here gets a value before any conditional
  // override, so no path can leave it unassigned and infer a latch.
  always_comb begin
    // Multiply: {acc_hi,acc_lo} holds partial product over the remaining multiplier bits.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
    nxt_hi  = mul_sum[WIDTH:1];
    nxt_lo  = {mul_sum[0], acc_lo[WIDTH-1:1]};
`ifdef MULDIV_HILO_DIV_EN
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift[WIDTH-1:0] - m;
    if (is_div) begin
      if (div_shift >= {1'b0, m}) begin
        nxt_hi = div_diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = div_shift[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with the HI/LO register pair.
// Define MULDIV_HILO_DIV_EN to include the divider; otherwise DIV/DIVU are no-ops.
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, m_op;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic             is_div, neg_res, neg_rem, div_zero;

  logic             signed_op;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;
  logic             take_mul, take_div;

  assign busy      = (state != ST_IDLE);
  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;

  assign take_mul = (state == ST_IDLE) && start && ((op == MD_MULT) || (op == MD_MULTU));
`ifdef MULDIV_HILO_DIV_EN
  assign take_div = (state == ST_IDLE) && start && ((op == MD_DIV) || (op == MD_DIVU));
`else
  assign take_div = 1'b0;
`endif

  // Sign correction applied in FIX; the iteration itself works on magnitudes.
  assign prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
  assign rem_fix  = neg_rem ? -acc_hi : acc_hi;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .m      (m_op),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && op == MD_MTHI) hi <= a;
          if (start && op == MD_MTLO) lo <= a;
          if (take_mul || take_div) begin
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: the datapath needs no reset; it is always loaded on acceptance
  // before its contents can reach HI/LO.
  always_ff @(posedge clock) begin
    if (take_mul) begin
      acc_hi   <= '0;
      acc_lo   <= b_mag;
      m_op     <= a_mag;
      is_div   <= 1'b0;
      neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else if (take_div) begin
      acc_hi   <= '0;
      acc_lo   <= a_mag;
      m_op     <= b_mag;
      is_div   <= 1'b1;
      neg_res  <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem  <= signed_op & a[WIDTH-1];
      div_zero <= (b == '0);
    end else if (state == ST_RUN) begin
      acc_hi <= nxt_hi;
      acc_lo <= nxt_lo;
    end
  end

endmodule

// File: tb/tb_muldiv_hilo.sv
// Randomized self-checking bench for muldiv_hilo against an arithmetic HI/LO model.
// Divide checks follow whether MULDIV_HILO_DIV_EN is defined.
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [W-1:0] exp_hi   = '0;
  logic [W-1:0] exp_lo   = '0;

  always #5 clock = ~clock;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
`ifdef MULDIV_HILO_DIV_EN
    return (o == MD_MULT) || (o == MD_MULTU) || (o == MD_DIV) || (o == MD_DIVU);
`else
    return (o == MD_MULT) || (o == MD_MULTU);
`endif
  endfunction

  // Architectural result of one accepted operation.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    case (o)
      MD_MULT: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {exp_hi, exp_lo} = p;
      end
      MD_MULTU: {exp_hi, exp_lo} = {32'b0, x} * {32'b0, y};
      MD_MTHI:  exp_hi = x;
      MD_MTLO:  exp_lo = x;
`ifdef MULDIV_HILO_DIV_EN
      MD_DIV: begin
        if (y == 0) begin
          exp_lo = '1; exp_hi = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          exp_lo = x; exp_hi = '0;
        end else begin
          exp_lo = $signed(x) / $signed(y);
          exp_hi = $signed(x) % $signed(y);
        end
      end
      MD_DIVU: begin
        if (y == 0) begin
          exp_lo = '1; exp_hi = x;
        end else begin
          exp_lo = x / y; exp_hi = x % y;
        end
      end
`endif
      default: ;
    endcase
  endtask

  // Caller is at a falling edge; returns at the falling edge after completion.
  task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int cyc;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom;
    if (is_long(o)) begin
      cyc = 0;
      while (busy && cyc < 100) begin
        check($sformatf("hold_hi op%0d", o), hi, exp_hi);
        check($sformatf("hold_lo op%0d", o), lo, exp_lo);
        check($sformatf("early_done op%0d", o), done, 0);
        cyc++;
        @(negedge clock);
      end
      check($sformatf("busy_cycles op%0d", o), cyc, W + 1);
      check($sformatf("done_pulse op%0d", o), done, 1);
    end else begin
      check($sformatf("short_busy op%0d", o), busy, 0);
      check($sformatf("short_done op%0d", o), done, 0);
    end
    model(o, x, y);
    check($sformatf("hi op%0d a=%0h b=%0h", o, x, y), hi, exp_hi);
    check($sformatf("lo op%0d a=%0h b=%0h", o, x, y), lo, exp_lo);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    bit  saw_done;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clock);
    check("reset_hi", hi, 0);
    check("reset_lo", lo, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    @(negedge clock);

    do_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("tp_multu_hi", hi, 32'hFFFF_FFFE);
    check("tp_multu_lo", lo, 32'h0000_0001);
    do_op(MD_MULT, 32'hFFFF_FFFE, 32'd3);
    check("tp_mult_hi", hi, 32'hFFFF_FFFF);
    check("tp_mult_lo", lo, 32'hFFFF_FFFA);
    do_op(MD_MTLO, 32'h1357_9BDF, 32'd0);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd2);
`ifdef MULDIV_HILO_DIV_EN
    check("tp_div_lo", lo, 32'hFFFF_FFFD);
    check("tp_div_hi", hi, 32'hFFFF_FFFF);
`endif
    do_op(MD_DIVU, 32'h0000_1234, 32'd0);
    do_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MD_DIV, 32'hFFFF_FFF9, 32'd0);
    do_op(MD_DIV, 32'h8000_0000, 32'd0);
    do_op(3'b110, 32'hDEAD_BEEF, 32'd1);
    do_op(3'b111, 32'hDEAD_BEEF, 32'd1);

    // MTHI then MULTU with an MTLO request arriving mid-run.
    do_op(MD_MTHI, 32'hAAAA_0000, 32'd0);
    start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1; op = MD_MTLO; a = 32'd1;
    @(negedge clock);
    start = 1'b0;
    check("midrun_hi_hold", hi, 32'hAAAA_0000);
    check("midrun_lo_hold", lo, exp_lo);
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clock); end
    check("midrun_done", done, 1);
    model(MD_MULTU, 32'd5, 32'd6);
    check("midrun_hi", hi, exp_hi);
    check("midrun_lo", lo, exp_lo);

    // Reset aborts an in-flight multiply.
    start = 1'b1; op = MD_MULTU; a = 32'hFFFF_0001; b = 32'h1234_5678;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

    // Reset wins over a same-edge start.
    start = 1'b1; op = MD_MTHI; a = 32'h5555_5555; reset = 1'b1;
    @(negedge clock);
    start = 1'b0; reset = 1'b0;
    check("rst_vs_start_busy", busy, 0);
    check("rst_vs_start_hi", hi, 0);

    for (int i = 0; i < 60; i++) begin
      do_op(3'($urandom_range(0, 7)), pick(), pick());
    end
    @(negedge clock);
    check("final_done_low", done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
